// File: rtl/aesl_deadlock_pkg.sv
// rtl/aesl_deadlock_pkg.sv - shared FSM encoding and defaults for the deadlock block detector
//
// Purpose : state encoding and default stable-blocked threshold, imported by the detector.
// Ports   : none (package).

package aesl_deadlock_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WATCH    = 2'd1,
      DECLARED = 2'd2
   } det_state_e;

   localparam int unsigned DEFAULT_THRESH = 16;

endpackage

// File: rtl/aesl_sat_counter.sv
// rtl/aesl_sat_counter.sv - saturating up-counter with synchronous clear and enable
//
// Purpose : counts enabled cycles, sticking at all-ones; clear has priority over enable.
// Ports   : clock  in   rising-edge clock
//           reset  in   synchronous active-low reset
//           clr    in   synchronous clear to zero
//           en     in   increment enable
//           count  out  CNT_W-bit count value

module aesl_sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_ONE = 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && (count_q != CNT_MAX)) begin
         count_d = count_q + CNT_ONE;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/aesl_deadlock_block_detector.sv
// rtl/aesl_deadlock_block_detector.sv - declares a kernel deadlock when the blocked set stops changing
//
// Purpose : registers the AXIS/instance blocking flags, tracks how long the (non-empty) blocked set
//           has been unchanged, and declares 'block' after THRESH stable cycles.
// Ports   : clock            in   monitor clock
//           reset            in   synchronous active-low reset
//           axis_block_sigs  in   per-AXIS-channel stall flags
//           inst_idle_sigs   in   per-instance idle flags
//           inst_block_sigs  in   per-instance blocked flags
//           block            out  deadlock declared (level)
//           block_rise       out  one-cycle pulse on block 0->1
//           block_vec        out  blocked set captured at declaration {inst_eff, axis}
//           block_cycles     out  saturating count of cycles spent declared

module aesl_deadlock_block_detector
   import aesl_deadlock_pkg::*;
#(
   parameter int unsigned N_AXIS = 2,
   parameter int unsigned N_INST = 1,
   parameter int unsigned THRESH = DEFAULT_THRESH,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [N_AXIS-1:0]        axis_block_sigs,
   input  logic [N_INST-1:0]        inst_idle_sigs,
   input  logic [N_INST-1:0]        inst_block_sigs,
   output logic                     block,
   output logic                     block_rise,
   output logic [N_AXIS+N_INST-1:0] block_vec,
   output logic [CNT_W-1:0]         block_cycles
);

   localparam int unsigned VW = N_AXIS + N_INST;
   localparam int unsigned SW = $clog2(THRESH + 1);
   localparam logic [SW-1:0] STABLE_ONE  = 1;
   localparam logic [SW-1:0] STABLE_LAST = SW'(THRESH - 1);

   logic [N_AXIS-1:0] axis_q, axis_d;
   logic [N_INST-1:0] idle_q, idle_d;
   logic [N_INST-1:0] iblk_q, iblk_d;

   det_state_e        state_q, state_d;
   logic [SW-1:0]     stable_q, stable_d;
   logic [VW-1:0]     snap_q, snap_d;
   logic              block_q, block_d;
   logic              rise_q, rise_d;
   logic [VW-1:0]     vec_q, vec_d;

   logic [VW-1:0]     cur_vec;
   logic              any_blk;
   logic              match;
   logic              thresh_hit;
   logic              cnt_en;
   logic              cnt_clr;

   assign axis_d = axis_block_sigs;
   assign idle_d = inst_idle_sigs;
   assign iblk_d = inst_block_sigs;

   // An idle instance is never treated as blocked.
   assign cur_vec = {iblk_q & ~idle_q, axis_q};
   assign any_blk = |cur_vec;
   assign match   = (cur_vec == snap_q);

   // With THRESH==1 the first matching WATCH cycle already declares.
   assign thresh_hit = (THRESH == 1) ? 1'b1 : (stable_q == STABLE_LAST);

   always_comb begin
      state_d  = state_q;
      stable_d = stable_q;
      snap_d   = snap_q;
      block_d  = block_q;
      rise_d   = 1'b0;
      vec_d    = vec_q;
      cnt_en   = 1'b0;
      cnt_clr  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (any_blk) begin
               snap_d   = cur_vec;
               stable_d = STABLE_ONE;
               state_d  = WATCH;
            end
         end

         WATCH: begin
            if (!any_blk) begin
               stable_d = '0;
               state_d  = IDLE;
            end else if (!match) begin
               // Blocked set changed: that is forward progress, restart the window.
               snap_d   = cur_vec;
               stable_d = STABLE_ONE;
            end else if (thresh_hit) begin
               state_d  = DECLARED;
               block_d  = 1'b1;
               rise_d   = 1'b1;
               vec_d    = snap_q;
               cnt_en   = 1'b1;
            end else begin
               stable_d = stable_q + STABLE_ONE;
            end
         end

         DECLARED: begin
            if (any_blk && match) begin
               cnt_en = 1'b1;
            end else begin
               // block_vec is deliberately left holding the declared set.
               block_d = 1'b0;
               cnt_clr = 1'b1;
               if (any_blk) begin
                  snap_d   = cur_vec;
                  stable_d = STABLE_ONE;
                  state_d  = WATCH;
               end else begin
                  stable_d = '0;
                  state_d  = IDLE;
               end
            end
         end

         default: begin
            stable_d = '0;
            block_d  = 1'b0;
            state_d  = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         axis_q   <= '0;
         idle_q   <= '0;
         iblk_q   <= '0;
         state_q  <= IDLE;
         stable_q <= '0;
         snap_q   <= '0;
         block_q  <= 1'b0;
         rise_q   <= 1'b0;
         vec_q    <= '0;
      end else begin
         axis_q   <= axis_d;
         idle_q   <= idle_d;
         iblk_q   <= iblk_d;
         state_q  <= state_d;
         stable_q <= stable_d;
         snap_q   <= snap_d;
         block_q  <= block_d;
         rise_q   <= rise_d;
         vec_q    <= vec_d;
      end
   end

   aesl_sat_counter #(
      .CNT_W (CNT_W)
   ) u_block_cycles (
      .clock (clock),
      .reset (reset),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .count (block_cycles)
   );

   assign block      = block_q;
   assign block_rise = rise_q;
   assign block_vec  = vec_q;

endmodule

// File: tb/tb_aesl_deadlock_block_detector.sv
// tb/tb_aesl_deadlock_block_detector.sv - self-checking bench for the deadlock block detector

module tb_aesl_deadlock_block_detector;

   logic       clock;
   logic       reset;
   logic [1:0] axis_block_sigs;
   logic [0:0] inst_idle_sigs;
   logic [0:0] inst_block_sigs;
   logic       block;
   logic       block_rise;
   logic [2:0] block_vec;
   logic [3:0] block_cycles;

   typedef struct {
      logic [1:0] axis;
      logic       idle;
      logic       iblk;
      int         hold;
      logic       exp_block;
      logic [2:0] exp_vec;
      logic [3:0] exp_cyc;
      int         exp_rise;
   } vec_t;

   vec_t vecs [17];
   vec_t sb [$];

   int n_checks = 0;
   int n_fail   = 0;
   int rise_total = 0;

   aesl_deadlock_block_detector #(
      .N_AXIS (2),
      .N_INST (1),
      .THRESH (16),
      .CNT_W  (4)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .axis_block_sigs (axis_block_sigs),
      .inst_idle_sigs  (inst_idle_sigs),
      .inst_block_sigs (inst_block_sigs),
      .block           (block),
      .block_rise      (block_rise),
      .block_vec       (block_vec),
      .block_cycles    (block_cycles)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) begin
      #1;
      if (block_rise === 1'b1) rise_total++;
   end

   task automatic check(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
      end
   endtask

   task automatic apply(input int step, input vec_t v);
      vec_t e;
      int   r0;
      axis_block_sigs = v.axis;
      inst_idle_sigs  = v.idle;
      inst_block_sigs = v.iblk;
      sb.push_back(v);
      r0 = rise_total;
      repeat (v.hold) @(posedge clock);
      @(negedge clock);
      e = sb.pop_front();
      check("block",        step, {31'd0, block},        {31'd0, e.exp_block});
      check("block_vec",    step, {29'd0, block_vec},    {29'd0, e.exp_vec});
      check("block_cycles", step, {28'd0, block_cycles}, {28'd0, e.exp_cyc});
      check("rise_pulses",  step, rise_total - r0,       e.exp_rise);
   endtask

   initial begin
      //            axis  idle  iblk  hold blk  vec     cyc   rises
      vecs[0]  = '{2'b01, 1'b0, 1'b0, 16, 1'b0, 3'b000, 4'd0,  0};
      vecs[1]  = '{2'b01, 1'b0, 1'b0, 1,  1'b1, 3'b001, 4'd1,  1};
      vecs[2]  = '{2'b01, 1'b0, 1'b0, 4,  1'b1, 3'b001, 4'd5,  0};
      vecs[3]  = '{2'b01, 1'b0, 1'b0, 10, 1'b1, 3'b001, 4'd15, 0};
      vecs[4]  = '{2'b01, 1'b0, 1'b0, 30, 1'b1, 3'b001, 4'd15, 0};
      vecs[5]  = '{2'b10, 1'b0, 1'b0, 1,  1'b1, 3'b001, 4'd15, 0};
      vecs[6]  = '{2'b10, 1'b0, 1'b0, 1,  1'b0, 3'b001, 4'd0,  0};
      vecs[7]  = '{2'b10, 1'b0, 1'b0, 14, 1'b0, 3'b001, 4'd0,  0};
      vecs[8]  = '{2'b10, 1'b0, 1'b0, 1,  1'b1, 3'b010, 4'd1,  1};
      vecs[9]  = '{2'b00, 1'b0, 1'b0, 1,  1'b1, 3'b010, 4'd2,  0};
      vecs[10] = '{2'b00, 1'b0, 1'b0, 1,  1'b0, 3'b010, 4'd0,  0};
      vecs[11] = '{2'b00, 1'b1, 1'b1, 100, 1'b0, 3'b010, 4'd0, 0};
      vecs[12] = '{2'b00, 1'b0, 1'b1, 17, 1'b1, 3'b100, 4'd1,  1};
      vecs[13] = '{2'b00, 1'b0, 1'b0, 2,  1'b0, 3'b100, 4'd0,  0};
      vecs[14] = '{2'b01, 1'b0, 1'b0, 10, 1'b0, 3'b100, 4'd0,  0};
      vecs[15] = '{2'b10, 1'b0, 1'b0, 17, 1'b1, 3'b010, 4'd1,  1};
      vecs[16] = '{2'b10, 1'b0, 1'b0, 3,  1'b1, 3'b010, 4'd4,  0};

      reset           = 1'b0;
      axis_block_sigs = 2'b11;
      inst_idle_sigs  = 1'b1;
      inst_block_sigs = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clock);
         @(negedge clock);
         check("rst_block",        c, {31'd0, block},        32'd0);
         check("rst_block_rise",   c, {31'd0, block_rise},   32'd0);
         check("rst_block_cycles", c, {28'd0, block_cycles}, 32'd0);
      end
      check("rst_block_vec", 3, {29'd0, block_vec}, 32'd0);

      reset = 1'b1;
      for (int i = 0; i < 17; i++) begin
         apply(i, vecs[i]);
      end

      // Reset pulse while declared aborts without a rise pulse.
      begin
         int r0;
         r0 = rise_total;
         reset = 1'b0;
         @(posedge clock);
         @(negedge clock);
         check("midrst_block",        100, {31'd0, block},        32'd0);
         check("midrst_block_rise",   100, {31'd0, block_rise},   32'd0);
         check("midrst_block_vec",    100, {29'd0, block_vec},    32'd0);
         check("midrst_block_cycles", 100, {28'd0, block_cycles}, 32'd0);
         check("midrst_rises",        100, rise_total - r0,       32'd0);
         reset = 1'b1;
      end

      apply(101, '{2'b10, 1'b0, 1'b0, 16, 1'b0, 3'b000, 4'd0, 0});
      apply(102, '{2'b10, 1'b0, 1'b0, 1,  1'b1, 3'b010, 4'd1, 1});

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
